// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - iterative MULT/MULTU/DIV/DIVU unit with pipeline stall and result-hold handshake
// Optional MDU_FAST_MULT_EN: MULT/MULTU skip the iterative loop and use one registered multiplier.
module mul_div_unit #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              req_valid_i,
    input  logic [1:0]        op_i,
    input  logic [DATA_W-1:0] src_a_i,
    input  logic [DATA_W-1:0] src_b_i,
    input  logic              exe_wr_i,
    input  logic              abort_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o
);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [DATA_W-1:0] opnd_q, hi_q, lo_q, res_hi_q, res_lo_q;
    logic              is_div_q, neg_q, sa_q;

    logic              accept, sa, sb, last_iter;
    logic [DATA_W-1:0] a_mag, b_mag;

    assign accept    = (state_q == S_IDLE) & req_valid_i & ~abort_i;
    assign sa        = ~op_i[0] & src_a_i[DATA_W-1];
    assign sb        = ~op_i[0] & src_b_i[DATA_W-1];
    assign a_mag     = sa ? -src_a_i : src_a_i;
    assign b_mag     = sb ? -src_b_i : src_b_i;
    assign last_iter = (cnt_q == CNT_W'(DATA_W - 1));

    // Multiply: hi_q accumulates, lo_q holds the multiplier and collects low product bits.
    // Divide: hi_q is the partial remainder, lo_q shifts dividend out and quotient bits in.
    logic [DATA_W:0]   mul_sum, div_shift;
    logic              div_ge;
    logic [DATA_W-1:0] div_rem;

    assign mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    assign div_shift = {hi_q, lo_q[DATA_W-1]};
    assign div_ge    = div_shift >= {1'b0, opnd_q};
    assign div_rem   = div_ge ? (div_shift[DATA_W-1:0] - opnd_q) : div_shift[DATA_W-1:0];

    logic [2*DATA_W-1:0] prod_mag, prod_fix;
    logic [DATA_W-1:0]   quo_fix, rem_fix;

`ifdef MDU_FAST_MULT_EN
    assign prod_mag = {{DATA_W{1'b0}}, opnd_q} * {{DATA_W{1'b0}}, lo_q};
`else
    assign prod_mag = {hi_q, lo_q};
`endif
    assign prod_fix = neg_q ? -prod_mag : prod_mag;
    assign quo_fix  = neg_q ? -lo_q : lo_q;
    assign rem_fix  = sa_q ? -hi_q : hi_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (abort_i) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
`ifdef MDU_FAST_MULT_EN
                        state_d = op_i[1] ? S_CALC : S_FIX;
`else
                        state_d = S_CALC;
`endif
                    end
                end
                S_CALC:  if (last_iter) state_d = S_FIX;
                S_FIX:   state_d = S_DONE;
                S_DONE:  if (exe_wr_i) state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // abort_i suppresses busy in the same cycle so the flush wins in pipeline control
    assign busy_o = (accept | (state_q == S_CALC) | (state_q == S_FIX)) & ~abort_i;
    assign done_o = (state_q == S_DONE);
    assign hi_o   = res_hi_q;
    assign lo_o   = res_lo_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q    <= '0;
            opnd_q   <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            res_hi_q <= '0;
            res_lo_q <= '0;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            sa_q     <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        cnt_q    <= '0;
                        is_div_q <= op_i[1];
                        neg_q    <= sa ^ sb;
                        sa_q     <= sa;
                        hi_q     <= '0;
                        opnd_q   <= op_i[1] ? b_mag : a_mag;
                        lo_q     <= op_i[1] ? a_mag : b_mag;
                    end
                end
                S_CALC: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (is_div_q) begin
                        hi_q <= div_rem;
                        lo_q <= {lo_q[DATA_W-2:0], div_ge};
                    end else begin
                        hi_q <= mul_sum[DATA_W:1];
                        lo_q <= {mul_sum[0], lo_q[DATA_W-1:1]};
                    end
                end
                S_FIX: begin
                    if (is_div_q) begin
                        res_hi_q <= rem_fix;
                        res_lo_q <= quo_fix;
                    end else begin
                        {res_hi_q, res_lo_q} <= prod_fix;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// tb/tb_mul_div_unit.sv - randomized self-checking bench for mul_div_unit against an arithmetic reference model
module tb_mul_div_unit;

    logic        clk = 1'b0;
    logic        resetn;
    logic        req_valid;
    logic [1:0]  op;
    logic [31:0] src_a, src_b;
    logic        exe_wr;
    logic        abort;
    logic        busy_o, done_o;
    logic [31:0] hi_o, lo_o;

    int tests_run = 0;
    int tests_failed = 0;

    mul_div_unit #(.DATA_W(32), .CNT_W(6)) dut (
        .clk(clk), .resetn(resetn), .req_valid_i(req_valid), .op_i(op),
        .src_a_i(src_a), .src_b_i(src_b), .exe_wr_i(exe_wr), .abort_i(abort),
        .busy_o(busy_o), .done_o(done_o), .hi_o(hi_o), .lo_o(lo_o)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] model(input logic [1:0] mop, input logic [31:0] a, input logic [31:0] b);
        longint x, y, q, r;
        logic [63:0] res;
        case (mop)
            2'd0: begin
                x = $signed(a);
                y = $signed(b);
                res = 64'(x * y);
            end
            2'd1: res = {32'b0, a} * {32'b0, b};
            2'd2: begin
                if (b == 0) begin
                    res = {a, (a[31] ? 32'h0000_0001 : 32'hFFFF_FFFF)};
                end else begin
                    x = $signed(a);
                    y = $signed(b);
                    q = x / y;
                    r = x % y;
                    res = {r[31:0], q[31:0]};
                end
            end
            default: begin
                if (b == 0) res = {a, 32'hFFFF_FFFF};
                else        res = {a % b, a / b};
            end
        endcase
        return res;
    endfunction

    function automatic int exp_busy(input logic [1:0] mop);
`ifdef MDU_FAST_MULT_EN
        if (!mop[1]) return 2;
`endif
        return 34;
    endfunction

    task automatic run_op(input logic [1:0] mop, input logic [31:0] a, input logic [31:0] b,
                          input bit release_it, output logic [31:0] hi, output logic [31:0] lo,
                          output int busy_cnt, output bit done_seen);
        int n;
        @(posedge clk); #1;
        req_valid = 1'b1; op = mop; src_a = a; src_b = b; exe_wr = 1'b0;
        #1;
        busy_cnt = busy_o ? 1 : 0;
        @(posedge clk); #1;
        req_valid = 1'b0; src_a = $urandom; src_b = $urandom; op = 2'($urandom);
        n = 0;
        while (!done_o && n < 200) begin
            if (busy_o) busy_cnt++;
            n++;
            @(posedge clk); #1;
        end
        done_seen = done_o;
        hi = hi_o;
        lo = lo_o;
        if (release_it) begin
            exe_wr = 1'b1;
            @(posedge clk); #1;
            exe_wr = 1'b0;
        end
    endtask

    task automatic test_reset;
        resetn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        tests_run++; if (busy_o !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b expected 0", busy_o); end
        tests_run++; if (done_o !== 1'b0) begin tests_failed++; $display("FAIL reset_done: got %b expected 0", done_o); end
        tests_run++; if (hi_o !== 32'h0) begin tests_failed++; $display("FAIL reset_hi: got %h expected 0", hi_o); end
        tests_run++; if (lo_o !== 32'h0) begin tests_failed++; $display("FAIL reset_lo: got %h expected 0", lo_o); end
        resetn = 1'b1;
    endtask

    task automatic test_directed;
        logic [1:0]  vop [5] = '{2'd1, 2'd2, 2'd3, 2'd2, 2'd0};
        logic [31:0] va  [5] = '{32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'd7, 32'h8000_0000, 32'hFFFF_FFFD};
        logic [31:0] vb  [5] = '{32'hFFFF_FFFF, 32'd2, 32'd0, 32'hFFFF_FFFF, 32'd5};
        logic [31:0] ehi [5] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd7, 32'h0, 32'hFFFF_FFFF};
        logic [31:0] elo [5] = '{32'h0000_0001, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFF1};
        logic [31:0] hi, lo;
        int bc;
        bit dn;
        for (int i = 0; i < 5; i++) begin
            run_op(vop[i], va[i], vb[i], 1'b1, hi, lo, bc, dn);
            tests_run++; if (dn !== 1'b1) begin tests_failed++; $display("FAIL dir%0d_done: got %b expected 1", i, dn); end
            tests_run++; if (hi !== ehi[i]) begin tests_failed++; $display("FAIL dir%0d_hi: got %h expected %h", i, hi, ehi[i]); end
            tests_run++; if (lo !== elo[i]) begin tests_failed++; $display("FAIL dir%0d_lo: got %h expected %h", i, lo, elo[i]); end
            tests_run++; if (bc !== exp_busy(vop[i])) begin tests_failed++; $display("FAIL dir%0d_busy_cycles: got %0d expected %0d", i, bc, exp_busy(vop[i])); end
        end
    endtask

    task automatic test_random;
        logic [1:0]  mop;
        logic [31:0] a, b, hi, lo;
        logic [63:0] exp;
        int bc;
        bit dn;
        for (int i = 0; i < 40; i++) begin
            mop = 2'($urandom);
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'h0;
                1: b = 32'hFFFF_FFFF;
                2: a = 32'h8000_0000;
                3: b = 32'($urandom_range(1, 15));
                default: ;
            endcase
            exp = model(mop, a, b);
            run_op(mop, a, b, 1'b1, hi, lo, bc, dn);
            tests_run++; if ({hi, lo} !== exp || dn !== 1'b1) begin tests_failed++; $display("FAIL rand%0d_result op=%0d a=%h b=%h: got %h done=%b expected %h", i, mop, a, b, {hi, lo}, dn, exp); end
            tests_run++; if (bc !== exp_busy(mop)) begin tests_failed++; $display("FAIL rand%0d_busy_cycles: got %0d expected %0d", i, bc, exp_busy(mop)); end
        end
    endtask

    task automatic test_abort;
        logic [31:0] hi, lo;
        int bc;
        bit dn, seen_done;
        @(posedge clk); #1;
        req_valid = 1'b1; op = 2'd2; src_a = 32'd1000; src_b = 32'd7; exe_wr = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        abort = 1'b1;
        #1;
        tests_run++; if (busy_o !== 1'b0) begin tests_failed++; $display("FAIL abort_busy_same_cycle: got %b expected 0", busy_o); end
        @(posedge clk); #1;
        abort = 1'b0;
        tests_run++; if (busy_o !== 1'b0 || done_o !== 1'b0) begin tests_failed++; $display("FAIL abort_idle_next: got busy=%b done=%b expected 0 0", busy_o, done_o); end
        seen_done = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done_o) seen_done = 1'b1;
        end
        tests_run++; if (seen_done !== 1'b0) begin tests_failed++; $display("FAIL abort_no_done: got %b expected 0", seen_done); end
        req_valid = 1'b1; abort = 1'b1; op = 2'd3; src_a = 32'd9; src_b = 32'd2;
        #1;
        tests_run++; if (busy_o !== 1'b0) begin tests_failed++; $display("FAIL abort_idle_req_busy: got %b expected 0", busy_o); end
        @(posedge clk); #1;
        req_valid = 1'b0; abort = 1'b0;
        tests_run++; if (busy_o !== 1'b0) begin tests_failed++; $display("FAIL abort_idle_no_accept: got %b expected 0", busy_o); end
        run_op(2'd3, 32'd100, 32'd7, 1'b1, hi, lo, bc, dn);
        tests_run++; if ({hi, lo} !== model(2'd3, 32'd100, 32'd7) || dn !== 1'b1) begin tests_failed++; $display("FAIL abort_next_op: got %h done=%b expected %h", {hi, lo}, dn, model(2'd3, 32'd100, 32'd7)); end
    endtask

    task automatic test_hold;
        logic [31:0] a, b, hi, lo;
        logic [63:0] exp;
        int bc;
        bit dn;
        a = $urandom;
        b = $urandom;
        exp = model(2'd0, a, b);
        run_op(2'd0, a, b, 1'b0, hi, lo, bc, dn);
        req_valid = 1'b1; op = 2'd3; src_a = 32'd50; src_b = 32'd3;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            tests_run++; if (done_o !== 1'b1 || busy_o !== 1'b0 || {hi_o, lo_o} !== exp) begin tests_failed++; $display("FAIL hold%0d: got done=%b busy=%b res=%h expected 1 0 %h", i, done_o, busy_o, {hi_o, lo_o}, exp); end
        end
        req_valid = 1'b0;
        exe_wr = 1'b1;
        @(posedge clk); #1;
        exe_wr = 1'b0;
        tests_run++; if (done_o !== 1'b0 || busy_o !== 1'b0) begin tests_failed++; $display("FAIL hold_release: got done=%b busy=%b expected 0 0", done_o, busy_o); end
    endtask

    task automatic test_reset_mid;
        logic [1:0]  mop;
        logic [31:0] a, b, hi, lo;
        logic [63:0] exp;
        int bc;
        bit dn;
        @(posedge clk); #1;
        req_valid = 1'b1; op = 2'd1; src_a = 32'h1234_5678; src_b = 32'h9ABC_DEF0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        resetn = 1'b0;
        #1;
        tests_run++; if ({busy_o, done_o, hi_o, lo_o} !== 66'h0) begin tests_failed++; $display("FAIL reset_mid_outputs: got busy=%b done=%b hi=%h lo=%h expected all 0", busy_o, done_o, hi_o, lo_o); end
        @(posedge clk); #1;
        resetn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            mop = 2'(i);
            a = $urandom;
            b = $urandom;
            exp = model(mop, a, b);
            run_op(mop, a, b, 1'b1, hi, lo, bc, dn);
            tests_run++; if ({hi, lo} !== exp || dn !== 1'b1) begin tests_failed++; $display("FAIL b2b%0d op=%0d: got %h done=%b expected %h", i, mop, {hi, lo}, dn, exp); end
        end
    endtask

    initial begin
        resetn = 1'b0; req_valid = 1'b0; op = 2'd0; src_a = '0; src_b = '0; exe_wr = 1'b0; abort = 1'b0;
        test_reset();
        test_directed();
        test_random();
        test_abort();
        test_hold();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
